// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder.
package spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_responder_if.sv
// Pin and host-side bundle of the SPI responder.
interface spi_responder_if;

    logic       SCK;
    logic       nSS;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ACK;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic       TX_FULL;
    logic [7:0] BYTE_CNT;
    logic       SELECTED;
    logic       OVERRUN;
    logic       UNDERRUN;
    logic       CLR_ERR;

    modport slave (
        input  SCK, nSS, MOSI, RX_ACK, TX_DATA, TX_LOAD, CLR_ERR,
        output MISO, MISO_OE, RX_DATA, RX_VALID, TX_FULL,
        output BYTE_CNT, SELECTED, OVERRUN, UNDERRUN
    );

    modport master (
        output SCK, nSS, MOSI, RX_ACK, TX_DATA, TX_LOAD, CLR_ERR,
        input  MISO, MISO_OE, RX_DATA, RX_VALID, TX_FULL,
        input  BYTE_CNT, SELECTED, OVERRUN, UNDERRUN
    );

endinterface

// File: rtl/spi_responder_sync.sv
// N-stage synchronizer with edge detect on the last stage.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] ff;
    logic              prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ff   <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            ff   <= {ff[STAGES-2:0], d};
            prev <= ff[STAGES-1];
        end
    end

    assign q    = ff[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0/2 responder: byte RX with ack, single-entry TX holding register.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CPOL        = 1'b0,
    parameter logic [7:0]  IDLE_BYTE   = DEF_IDLE_BYTE
) (
    input logic            CLK,
    input logic            RST,
    spi_responder_if.slave bus
);

    state_t state, state_nx;

    logic sck_q_unused, sck_rise, sck_fall;
    logic nss_q, nss_rise_unused, nss_fall_unused;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    logic [SYNC_STAGES-1:0] flush;
    logic                   armed;

    logic       start, active, abort;
    logic       lead_a, trail_a, byte_done, tx_xfer;
    logic       ovr_set, und_set;
    logic [7:0] rx_byte;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, rx_data, tx_shift, tx_hold, byte_cnt;
    logic       rx_valid, tx_full, overrun, underrun;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
        .CLK(CLK), .RST(RST), .d(bus.SCK),
        .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss (
        .CLK(CLK), .RST(RST), .d(bus.nSS),
        .q(nss_q), .rise(nss_rise_unused), .fall(nss_fall_unused)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .CLK(CLK), .RST(RST), .d(bus.MOSI),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Arm only once nSS has been seen high through a flushed chain,
    // so a select held across reset cannot start mid-byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush <= '0;
            armed <= 1'b0;
        end else begin
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
            if (flush[SYNC_STAGES-1] && nss_q)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (armed && !nss_q) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (nss_q) state_nx = ST_ABORT;
            ST_ABORT:  state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        active = 1'b0;
        abort  = 1'b0;
        unique case (state)
            ST_IDLE:   start  = (state_nx == ST_ACTIVE);
            ST_ACTIVE: active = 1'b1;
            ST_ABORT:  abort  = 1'b1;
            default:   ;
        endcase
    end

    assign lead_a    = active && (CPOL ? sck_fall : sck_rise);
    assign trail_a   = active && (CPOL ? sck_rise : sck_fall);
    assign byte_done = lead_a && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift[6:0], mosi_q};
    assign tx_xfer   = start || (trail_a && (bit_cnt == 3'd0));
    assign ovr_set   = byte_done && rx_valid && !bus.RX_ACK;
    assign und_set   = tx_xfer && !tx_full && !bus.TX_LOAD;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (start || abort) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (lead_a) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (byte_done && (!rx_valid || bus.RX_ACK)) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
        end else if (bus.RX_ACK) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            byte_cnt <= '0;
        else if (start)     byte_cnt <= '0;
        else if (byte_done) byte_cnt <= byte_cnt + 8'd1;
    end

    // A load landing on an empty-register transfer bypasses the holding reg.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
        end else if (tx_xfer) begin
            if (tx_full) begin
                tx_shift <= tx_hold;
                tx_full  <= 1'b0;
            end else if (bus.TX_LOAD) begin
                tx_shift <= bus.TX_DATA;
            end else begin
                tx_shift <= IDLE_BYTE;
            end
        end else begin
            if (trail_a)
                tx_shift <= {tx_shift[6:0], 1'b0};
            if (bus.TX_LOAD && !tx_full) begin
                tx_hold <= bus.TX_DATA;
                tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (bus.CLR_ERR) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ovr_set) overrun  <= 1'b1;
            if (und_set) underrun <= 1'b1;
        end
    end

    assign bus.MISO     = active & tx_shift[7];
    assign bus.MISO_OE  = active;
    assign bus.SELECTED = active;
    assign bus.RX_DATA  = rx_data;
    assign bus.RX_VALID = rx_valid;
    assign bus.TX_FULL  = tx_full;
    assign bus.BYTE_CNT = byte_cnt;
    assign bus.OVERRUN  = overrun;
    assign bus.UNDERRUN = underrun;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder in SPI mode 0.
module tb_spi_responder;

    localparam int HALF = 6;

    logic CLK;
    logic RST;
    logic mon;
    logic vpulse;
    int   n_chk;
    int   n_fail;

    spi_responder_if bus();

    spi_responder #(
        .SYNC_STAGES(2),
        .CPOL(1'b0),
        .IDLE_BYTE(8'hFF)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!mon)              vpulse <= 1'b0;
        else if (bus.RX_VALID) vpulse <= 1'b1;
    end

    task automatic spi_xfer(input logic [7:0] d, input int n,
                            output logic [7:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            bus.MOSI = d[7-i];
            repeat (HALF) @(negedge CLK);
            m = {m[6:0], bus.MISO};
            bus.SCK = 1'b1;
            repeat (HALF) @(negedge CLK);
            bus.SCK = 1'b0;
        end
        repeat (HALF) @(negedge CLK);
    endtask

    task automatic sel(input logic v);
        bus.nSS = ~v;
        repeat (8) @(negedge CLK);
    endtask

    task automatic pulse_ack();
        bus.RX_ACK = 1'b1;
        @(negedge CLK);
        bus.RX_ACK = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_clr();
        bus.CLR_ERR = 1'b1;
        @(negedge CLK);
        bus.CLR_ERR = 1'b0;
        @(negedge CLK);
    endtask

    task automatic load_tx(input logic [7:0] d);
        bus.TX_DATA = d;
        bus.TX_LOAD = 1'b1;
        @(negedge CLK);
        bus.TX_LOAD = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        flags = {bus.MISO, bus.MISO_OE, bus.RX_VALID, bus.TX_FULL,
                 bus.SELECTED, bus.OVERRUN, bus.UNDERRUN};
        n_chk++;
        if (flags !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", flags, 7'b0);
        end
        n_chk++;
        if (bus.RX_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h expected 00", bus.RX_DATA);
        end
        n_chk++;
        if (bus.BYTE_CNT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_byte_cnt: got %h expected 00", bus.BYTE_CNT);
        end
    endtask

    task automatic test_basic();
        logic [7:0] m;
        load_tx(8'hA5);
        n_chk++;
        if (bus.TX_FULL !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_tx_full: got %b expected 1", bus.TX_FULL);
        end
        sel(1'b1);
        n_chk++;
        if ({bus.SELECTED, bus.MISO_OE, bus.TX_FULL} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_select: got %b expected 110",
                     {bus.SELECTED, bus.MISO_OE, bus.TX_FULL});
        end
        spi_xfer(8'h3C, 8, m);
        n_chk++;
        if (m !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_miso: got %h expected a5", m);
        end
        n_chk++;
        if (bus.RX_DATA !== 8'h3C || bus.RX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_rx: got %h/%b expected 3c/1",
                     bus.RX_DATA, bus.RX_VALID);
        end
        n_chk++;
        if (bus.BYTE_CNT !== 8'd1 || bus.OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d/%b expected 1/0",
                     bus.BYTE_CNT, bus.OVERRUN);
        end
        sel(1'b0);
        n_chk++;
        if ({bus.SELECTED, bus.MISO_OE, bus.MISO} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_deselect: got %b expected 000",
                     {bus.SELECTED, bus.MISO_OE, bus.MISO});
        end
        pulse_ack();
        n_chk++;
        if (bus.RX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack: got %b expected 0", bus.RX_VALID);
        end
        pulse_clr();
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        sel(1'b1);
        spi_xfer(8'h11, 8, m);
        spi_xfer(8'h22, 8, m);
        spi_xfer(8'h33, 8, m);
        n_chk++;
        if (bus.RX_DATA !== 8'h11 || bus.OVERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_rx: got %h/%b expected 11/1",
                     bus.RX_DATA, bus.OVERRUN);
        end
        n_chk++;
        if (bus.BYTE_CNT !== 8'd3) begin
            n_fail++;
            $display("FAIL ovr_cnt: got %0d expected 3", bus.BYTE_CNT);
        end
        sel(1'b0);
        pulse_ack();
        pulse_clr();
        n_chk++;
        if (bus.OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b expected 0", bus.OVERRUN);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        n_chk++;
        if (bus.UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL und_pre: got %b expected 0", bus.UNDERRUN);
        end
        sel(1'b1);
        spi_xfer(8'h5A, 8, m);
        n_chk++;
        if (m !== 8'hFF || bus.UNDERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL und_miso: got %h/%b expected ff/1",
                     m, bus.UNDERRUN);
        end
        n_chk++;
        if (bus.RX_DATA !== 8'h5A) begin
            n_fail++;
            $display("FAIL und_rx: got %h expected 5a", bus.RX_DATA);
        end
        sel(1'b0);
        pulse_clr();
        n_chk++;
        if (bus.UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL und_clear: got %b expected 0", bus.UNDERRUN);
        end
        pulse_ack();
    endtask

    task automatic test_abort();
        logic [7:0] m;
        sel(1'b1);
        spi_xfer(8'hFF, 5, m);
        load_tx(8'h96);
        bus.nSS = 1'b1;
        repeat (6) @(negedge CLK);
        n_chk++;
        if ({bus.MISO_OE, bus.MISO, bus.TX_FULL} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_gap: got %b expected 001",
                     {bus.MISO_OE, bus.MISO, bus.TX_FULL});
        end
        repeat (6) @(negedge CLK);
        sel(1'b1);
        spi_xfer(8'h81, 8, m);
        n_chk++;
        if (m !== 8'h96) begin
            n_fail++;
            $display("FAIL abort_tx_kept: got %h expected 96", m);
        end
        n_chk++;
        if (bus.RX_DATA !== 8'h81 || bus.RX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rx: got %h/%b expected 81/1",
                     bus.RX_DATA, bus.RX_VALID);
        end
        n_chk++;
        if (bus.BYTE_CNT !== 8'd1 || bus.OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cnt: got %0d/%b expected 1/0",
                     bus.BYTE_CNT, bus.OVERRUN);
        end
        sel(1'b0);
        pulse_ack();
        pulse_clr();
    endtask

    task automatic test_wrap();
        logic [7:0] m;
        logic [7:0] d;
        sel(1'b1);
        for (int i = 0; i < 255; i++) begin
            d = i[7:0];
            spi_xfer(d, 8, m);
        end
        n_chk++;
        if (bus.BYTE_CNT !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255: got %0d expected 255", bus.BYTE_CNT);
        end
        spi_xfer(8'hEE, 8, m);
        n_chk++;
        if (bus.BYTE_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_0: got %0d expected 0", bus.BYTE_CNT);
        end
        sel(1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        pulse_ack();
        sel(1'b1);
        spi_xfer(8'h77, 8, m);
        load_tx(8'h99);
        spi_xfer(8'hF0, 4, m);
        n_chk++;
        if (bus.RX_DATA !== 8'h77 || bus.TX_FULL !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got %h/%b expected 77/1",
                     bus.RX_DATA, bus.TX_FULL);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        test_reset();
        mon = 1'b1;
        RST = 1'b0;
        spi_xfer(8'h0F, 4, m);
        repeat (10) @(negedge CLK);
        n_chk++;
        if (vpulse !== 1'b0 || bus.SELECTED !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_quiet: got %b/%b expected 0/0",
                     vpulse, bus.SELECTED);
        end
        mon = 1'b0;
        sel(1'b0);
        load_tx(8'h3C);
        sel(1'b1);
        spi_xfer(8'hA5, 8, m);
        n_chk++;
        if (m !== 8'h3C || bus.RX_DATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL rmid_next: got %h/%h expected 3c/a5",
                     m, bus.RX_DATA);
        end
        n_chk++;
        if (bus.RX_VALID !== 1'b1 || bus.BYTE_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL rmid_next_cnt: got %b/%0d expected 1/1",
                     bus.RX_VALID, bus.BYTE_CNT);
        end
        sel(1'b0);
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        mon         = 1'b0;
        RST         = 1'b1;
        bus.SCK     = 1'b0;
        bus.nSS     = 1'b1;
        bus.MOSI    = 1'b0;
        bus.RX_ACK  = 1'b0;
        bus.TX_DATA = 8'h00;
        bus.TX_LOAD = 1'b0;
        bus.CLR_ERR = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        test_basic();
        test_overrun();
        test_underrun();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
